// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - interrupt sequencer: synchronises irq_req and injects IRQ at a safe ID instruction
module irq_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int GUARD       = 4,
  parameter int MAX_WAIT    = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_req,
  input  logic kernel_mode,
  input  logic id_valid,
  input  logic id_is_jb,
  input  logic ex_is_jb,
  input  logic stall,
  output logic irq_take,
  output logic flush_if,
  output logic irq_ack,
  output logic in_service,
  output logic wait_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [3:0] GUARD_LD  = 4'(GUARD);
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   safe;
  logic                   handler_ret;
  logic                   wait_entry;
  logic                   wait_miss;
  logic [3:0]             guard_cnt;
  logic [7:0]             wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_req};
    end
  end

  assign req_s       = sync_q[SYNC_STAGES-1];
  assign safe        = id_valid & ~kernel_mode & ~id_is_jb & ~ex_is_jb & ~stall;
  assign handler_ret = id_valid & ~kernel_mode;
  assign wait_entry  = (state == ST_IDLE) & req_s & (guard_cnt == 4'd0);
  assign wait_miss   = (state == ST_WAIT) & ~safe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (wait_entry) state_nxt = ST_WAIT;
      // a take wins over a withdrawn request seen in the same cycle
      ST_WAIT: begin
        if (safe)        state_nxt = ST_SERVICE;
        else if (!req_s) state_nxt = ST_IDLE;
      end
      ST_SERVICE: if (handler_ret) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    irq_take   = 1'b0;
    in_service = 1'b0;
    case (state)
      ST_WAIT:    irq_take   = safe;
      ST_SERVICE: in_service = 1'b1;
      default:    ;
    endcase
  end

  assign flush_if = irq_take;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_ack   <= 1'b0;
      guard_cnt <= 4'd0;
      wait_cnt  <= 8'd0;
      wait_ovf  <= 1'b0;
    end else begin
      irq_ack <= irq_take;
      if ((state == ST_SERVICE) && handler_ret) begin
        guard_cnt <= GUARD_LD;
      end else if (guard_cnt != 4'd0) begin
        guard_cnt <= guard_cnt - 4'd1;
      end
      if (wait_entry) begin
        wait_cnt <= 8'd0;
      end else if (wait_miss && (wait_cnt != 8'hFF)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      // sticky: set on the miss that brings the count up to MAX_WAIT
      if (wait_miss && (wait_cnt == WAIT_LAST)) begin
        wait_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - self-checking bench for irq_sequencer against a cycle-count reference model
module tb_irq_sequencer;

  localparam int SYNC = 2;
  localparam int GRD  = 4;
  localparam int MAXW = 10;

  logic clk = 1'b0;
  logic reset;
  logic irq_req;
  logic kernel_mode;
  logic id_valid;
  logic id_is_jb;
  logic ex_is_jb;
  logic stall;
  logic irq_take;
  logic flush_if;
  logic irq_ack;
  logic in_service;
  logic wait_ovf;

  irq_sequencer #(
    .SYNC_STAGES(SYNC),
    .GUARD      (GRD),
    .MAX_WAIT   (MAXW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_req    (irq_req),
    .kernel_mode(kernel_mode),
    .id_valid   (id_valid),
    .id_is_jb   (id_is_jb),
    .ex_is_jb   (ex_is_jb),
    .stall      (stall),
    .irq_take   (irq_take),
    .flush_if   (flush_if),
    .irq_ack    (irq_ack),
    .in_service (in_service),
    .wait_ovf   (wait_ovf)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: phase 0 idle, 1 pending, 2 in handler; guard and
  // overflow are tracked as absolute cycle numbers / counts of missed cycles
  bit m_sync[$];
  int m_phase;
  int m_cyc;
  int m_ret_cyc;
  int m_waited;
  bit m_ovf;
  bit m_last_take;

  bit seen_take;
  bit seen_ack;
  bit seen_svc;
  bit seen_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit safe_now();
    return id_valid && !kernel_mode && !id_is_jb && !ex_is_jb && !stall;
  endfunction

  task automatic model_reset();
    m_sync.delete();
    m_phase     = 0;
    m_ret_cyc   = m_cyc - 100;
    m_waited    = 0;
    m_ovf       = 1'b0;
    m_last_take = 1'b0;
  endtask

  task automatic step();
    bit exp_take;
    bit req_s_m;
    bit dropped;
    @(negedge clk);
    exp_take = (m_phase == 1) && safe_now();
    check("take", irq_take, exp_take);
    check("flush", flush_if, exp_take);
    check("ack", irq_ack, m_last_take);
    check("svc", in_service, m_phase == 2);
    check("ovf", wait_ovf, m_ovf);
    seen_take = irq_take;
    seen_ack  = irq_ack;
    seen_svc  = in_service;
    seen_ovf  = wait_ovf;
    @(posedge clk);
    req_s_m = (m_sync.size() == SYNC) ? m_sync[0] : 1'b0;
    case (m_phase)
      0: if (req_s_m && (m_cyc - m_ret_cyc > GRD)) begin
        m_phase  = 1;
        m_waited = 0;
      end
      1: if (safe_now()) begin
        m_phase = 2;
      end else begin
        m_waited++;
        if (m_waited >= MAXW) m_ovf = 1'b1;
        if (!req_s_m) m_phase = 0;
      end
      default: if (id_valid && !kernel_mode) begin
        m_phase   = 0;
        m_ret_cyc = m_cyc;
      end
    endcase
    m_last_take = exp_take;
    m_sync.push_back(irq_req);
    if (m_sync.size() > SYNC) dropped = m_sync.pop_front();
    m_cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_take", irq_take, 0);
    check("rst_flush", flush_if, 0);
    check("rst_ack", irq_ack, 0);
    check("rst_svc", in_service, 0);
    check("rst_ovf", wait_ovf, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic set_safe();
    id_valid    = 1'b1;
    kernel_mode = 1'b0;
    id_is_jb    = 1'b0;
    ex_is_jb    = 1'b0;
    stall       = 1'b0;
  endtask

  task automatic to_idle();
    irq_req = 1'b0;
    set_safe();
    repeat (12) step();
  endtask

  initial begin
    int first;
    int takes;
    int acks;
    int outs;
    m_cyc   = 0;
    irq_req = 1'b0;
    set_safe();
    do_reset();

    // basic take: earliest take 3 cycles after the rise, ack and in_service one later
    irq_req = 1'b1;
    first   = -1;
    for (int k = 0; k < 8; k++) begin
      if (k >= 4) kernel_mode = 1'b1;
      step();
      if (seen_take && first < 0) first = k;
      if (k == 4) begin
        check("basic_ack", seen_ack, 1);
        check("basic_svc", seen_svc, 1);
      end
    end
    check("basic_take_cyc", first, 3);

    // handler return with request still held: next take GUARD+2 cycles after return
    kernel_mode = 1'b0;
    step();
    check("ret_svc_hi", seen_svc, 1);
    first = -1;
    for (int k = 1; k < 10; k++) begin
      if (k >= 7) kernel_mode = 1'b1;
      step();
      if (k == 1) check("ret_svc_lo", seen_svc, 0);
      if (seen_take && first < 0) first = k;
    end
    check("guard_take_cyc", first, GRD + 2);

    // branch shadow
    to_idle();
    irq_req  = 1'b1;
    id_is_jb = 1'b1;
    first    = -1;
    for (int k = 0; k < 9; k++) begin
      if (k == 4) begin
        id_is_jb = 1'b0;
        ex_is_jb = 1'b1;
      end
      if (k == 5) ex_is_jb = 1'b0;
      if (k >= 6) kernel_mode = 1'b1;
      step();
      if (seen_take && first < 0) first = k;
    end
    check("shadow_take_cyc", first, 5);

    // kernel for 5 pending cycles, then stall for 2
    to_idle();
    irq_req     = 1'b1;
    kernel_mode = 1'b1;
    first       = -1;
    for (int k = 0; k < 13; k++) begin
      if (k == 8) begin
        kernel_mode = 1'b0;
        stall       = 1'b1;
      end
      if (k == 10) stall = 1'b0;
      if (k >= 11) kernel_mode = 1'b1;
      step();
      if (seen_take && first < 0) first = k;
    end
    check("kstall_take_cyc", first, 10);

    // overflow while blocked, then withdraw
    to_idle();
    irq_req  = 1'b1;
    id_is_jb = 1'b1;
    takes    = 0;
    acks     = 0;
    for (int k = 0; k < 25; k++) begin
      if (k == 16) irq_req = 1'b0;
      if (k == 20) id_is_jb = 1'b0;
      step();
      takes += int'(seen_take);
      acks  += int'(seen_ack);
      if (k == 12) check("ovf_before", seen_ovf, 0);
      if (k == 13) check("ovf_at", seen_ovf, 1);
    end
    check("withdraw_takes", takes, 0);
    check("withdraw_acks", acks, 0);
    check("ovf_sticky", seen_ovf, 1);

    // reset in the middle of service
    to_idle();
    irq_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k >= 4) kernel_mode = 1'b1;
      step();
    end
    check("pre_rst_svc", seen_svc, 1);
    irq_req = 1'b0;
    do_reset();
    outs = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      outs += int'(seen_take) + int'(seen_ack) + int'(seen_svc) + int'(seen_ovf);
    end
    check("post_rst_quiet", outs, 0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      if ($urandom_range(0, 15) == 0) irq_req = ~irq_req;
      id_valid    = ($urandom_range(0, 3) != 0);
      kernel_mode = ($urandom_range(0, 2) == 0);
      id_is_jb    = ($urandom_range(0, 3) == 0);
      ex_is_jb    = ($urandom_range(0, 3) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Interrupt sequencer for the 5-stage MIPS pipeline. Synchronises the external interrupt request and waits for a safe ID-stage instruction: user mode, not a jump/branch, not shadowed by a jump/branch in EX, not stalled. It then drives the decoder's `IRQ` input for exactly one cycle, flushing IF, and blocks further interrupts until the handler returns to user mode plus a guard interval. Sits beside the ID-stage decoder; consumes its `isJ`/`isBranch` outputs and feeds its `IRQ` input.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth for `irq_req` (2..3).
- `GUARD`, 4: user-mode cycles after handler return before a new take is allowed (0..15).
- `MAX_WAIT`, 255: WAIT cycles after which `wait_ovf` sets (1..255).

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `irq_req` in 1: level interrupt request from timer peripheral; asynchronous to `clk`.
- `kernel_mode` in 1: PC[31] of the ID-stage instruction.
- `id_valid` in 1: ID holds a real instruction, not a bubble.
- `id_is_jb` in 1: ID instruction is a jump or branch (`isJ | isBranch`).
- `ex_is_jb` in 1: EX instruction is a jump or branch.
- `stall` in 1: pipeline hold (load-use); ID does not advance this cycle.
- `irq_take` out 1: to decoder `IRQ`; one-cycle pulse.
- `flush_if` out 1: squash IF instruction; equals `irq_take`.
- `irq_ack` out 1: one-cycle acknowledge to peripheral, registered.
- `in_service` out 1: high from take until handler return.
- `wait_ovf` out 1: sticky, pending request waited longer than `MAX_WAIT`.

## Operation
- Synchroniser: `SYNC_STAGES` flops on `irq_req`, giving `req_s`.
- `safe` = `id_valid & !kernel_mode & !id_is_jb & !ex_is_jb & !stall`.
- State machine, with reset state IDLE:
  - IDLE: if `req_s` and guard counter is 0, go to WAIT next cycle.
  - WAIT: `irq_take` = `safe`. This is combinational from registered state and the current-cycle inputs. On `safe`, go to SERVICE. If `req_s` drops before `safe`, return to IDLE with no take; the request is withdrawn.
  - SERVICE: `in_service` = 1. Leave for IDLE on the first cycle with `id_valid & !kernel_mode`, which is the handler return. On that transition, load the guard counter with `GUARD`.
- Guard counter (4 bits): decrements by 1 each cycle while nonzero, in any state; saturates at 0.
- Wait counter (8 bits):
  - Clears on WAIT entry.
  - Increments each WAIT cycle without a take, saturating at 255.
  - When it reaches `MAX_WAIT`, `wait_ovf` sets. It clears only on reset.
- `irq_ack`: registered copy of `irq_take`.
- Priority: `irq_take` overrides any exception decoded on the same ID instruction. The faulting instruction re-executes after return.
- `req_s` high while in SERVICE is ignored. It is re-evaluated in IDLE after the guard expires, so a level that is still held yields a new take.

## Timing
- Reset values (asynchronous, immediate): state IDLE; `irq_take` 0, `flush_if` 0, `irq_ack` 0, `in_service` 0, `wait_ovf` 0; guard and wait counters 0; synchroniser flops 0.
- Latency from `irq_req` rise to the earliest `irq_take` is `SYNC_STAGES`+1 cycles, assuming `safe` holds.
- `irq_take` and `flush_if` are high for exactly one cycle per take.
- `irq_ack` is high on the cycle after `irq_take`. `in_service` rises the same cycle as `irq_ack`.
- While `stall` is high, no take occurs. This guarantees the ID instruction that receives `IRQ` is the one that advances.
- After a return, the earliest next take is `GUARD`+2 cycles later (at `GUARD`=0: IDLE→WAIT→take).
- Reset asserted mid-SERVICE or mid-WAIT aborts immediately. No `irq_ack` is issued for an aborted WAIT.

## Test plan
- Basic take: `irq_req`=1 with `safe` held → `irq_take`=1 exactly at cycle 3 after the rise (`SYNC_STAGES`=2); `irq_ack`=1 at cycle 4; `in_service`=1 from cycle 4.
- Branch shadow: request pending, `id_is_jb`=1 for 1 cycle, then `ex_is_jb`=1 for 1 cycle, then `safe` → no take during either blocked cycle; take on the first clean cycle.
- Kernel/stall block: pending request with `kernel_mode`=1 for 5 cycles, then `stall`=1 for 2 cycles → no take in those 7 cycles; take on cycle 8.
- Return and guard: in SERVICE, present `id_valid`=1, `kernel_mode`=0 with `irq_req` held and `GUARD`=4 → `in_service` falls; next `irq_take` comes exactly 6 cycles after the return cycle.
- Overflow and withdraw: hold `id_is_jb`=1 with `MAX_WAIT`=10 → `wait_ovf`=1 after 10 WAIT cycles and stays 1. Then drop `irq_req` → return to IDLE, no `irq_take`, no `irq_ack`.
- Reset mid-operation: assert `reset`=0 while in SERVICE → all outputs 0 immediately. After release with `irq_req` low, outputs stay 0.
